// File: rtl/img_mem_ctrl_pkg.sv
// Shared types and constants for the image memory controller.
package img_mem_ctrl_pkg;

    // Default geometry: one 28x28 image of 8-bit pixels.
    localparam int unsigned NPIX_DEFAULT = 784;
    localparam int unsigned PIX_W        = 8;
    localparam int unsigned IMG_AW       = 10;

    // Ownership of the image buffer.
    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        FULL    = 2'd1,
        COMPUTE = 2'd2
    } state_e;

endpackage

// File: rtl/img_pix_counter.sv
// Pixel write counter: counts 0..NPIX-1, wraps to 0 after the last pixel.
module img_pix_counter
    import img_mem_ctrl_pkg::*;
#(
    parameter int unsigned NPIX = NPIX_DEFAULT,
    parameter int unsigned AW   = IMG_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          inc,
    output logic [AW-1:0] count,
    output logic          last
);

    localparam logic [AW-1:0] LastIdx = AW'(NPIX - 1);

    logic [AW-1:0] count_q;
    logic [AW-1:0] count_d;

    assign count = count_q;
    assign last  = (count_q == LastIdx);

    // Next count: clear wins over increment; wrap at the last pixel.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc) begin
            count_d = last ? '0 : count_q + AW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/img_mem_ctrl.sv
// Image buffer controller: arbitrates a single-port RAM between the host
// loader and the compute engine, one complete image at a time.
module img_mem_ctrl
    import img_mem_ctrl_pkg::*;
#(
    parameter int unsigned NPIX = NPIX_DEFAULT,
    parameter int unsigned DW   = PIX_W,
    parameter int unsigned AW   = IMG_AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_valid,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ready,
    input  logic          start,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    input  logic          compute_done,
    input  logic          abort,
    output logic          img_ready,
    output logic          busy,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    state_e state_q;
    state_e state_d;

    logic          accept;
    logic          rd_fire;
    logic          rd_in_range;
    logic [AW-1:0] wr_cnt;
    logic          wr_last;
    logic [AW-1:0] mem_addr_q;
    logic          rd_valid_q;
    logic          rd_oob_q;

    assign wr_ready    = (state_q == LOAD);
    assign accept      = wr_valid & wr_ready;
    assign rd_fire     = rd_req & (state_q == COMPUTE);
    assign rd_in_range = (32'(rd_addr) < NPIX);
    assign img_ready   = (state_q == FULL);
    assign busy        = (state_q == COMPUTE);

    // A write in the abort cycle still lands in RAM but the count restarts.
    img_pix_counter #(
        .NPIX (NPIX),
        .AW   (AW)
    ) u_pix_counter (
        .clk   (clk),
        .reset (reset),
        .clear (abort),
        .inc   (accept & ~abort),
        .count (wr_cnt),
        .last  (wr_last)
    );

    // Next-state logic; abort overrides every other request.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = LOAD;
        end else begin
            unique case (state_q)
                LOAD:    if (accept && wr_last) state_d = FULL;
                FULL:    if (start)             state_d = COMPUTE;
                COMPUTE: if (compute_done)      state_d = LOAD;
                default:                        state_d = LOAD;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // RAM port mux; out-of-range reads leave the address bus untouched.
    always_comb begin
        mem_we    = accept;
        mem_wdata = accept ? wr_data : '0;
        mem_addr  = mem_addr_q;
        if (accept) begin
            mem_addr = wr_cnt;
        end else if (rd_fire && rd_in_range) begin
            mem_addr = rd_addr;
        end
    end

    // Address hold and read-pipeline tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr_q <= '0;
            rd_valid_q <= 1'b0;
            rd_oob_q   <= 1'b0;
        end else begin
            mem_addr_q <= mem_addr;
            rd_valid_q <= rd_fire;
            rd_oob_q   <= rd_fire & ~rd_in_range;
        end
    end

    // RAM data arrives with the valid; out-of-range reads return zero.
    assign rd_valid = rd_valid_q;
    assign rd_data  = (rd_valid_q && !rd_oob_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_img_mem_ctrl.sv
// Self-checking bench for img_mem_ctrl against a cycle-level behavioural model.
module tb_img_mem_ctrl;
    import img_mem_ctrl_pkg::*;

    localparam int unsigned NPIX = NPIX_DEFAULT;
    localparam int unsigned DW   = PIX_W;
    localparam int unsigned AW   = IMG_AW;

    localparam int M_LOAD = 0;
    localparam int M_FULL = 1;
    localparam int M_COMP = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          start;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          compute_done;
    logic          abort;
    logic          img_ready;
    logic          busy;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    img_mem_ctrl #(
        .NPIX (NPIX),
        .DW   (DW),
        .AW   (AW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .start        (start),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .compute_done (compute_done),
        .abort        (abort),
        .img_ready    (img_ready),
        .busy         (busy),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port RAM with one-cycle read latency.
    logic [DW-1:0] ram [0:1023];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    // Reference model state.
    int          mode;
    int          wcnt;
    int          last_addr;
    bit          pend_valid;
    int          pend_data;
    logic [7:0]  img [0:1023];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mode       = M_LOAD;
        wcnt       = 0;
        last_addr  = 0;
        pend_valid = 0;
        pend_data  = 0;
    endtask

    // One clock: drive inputs, check outputs against the model, advance the model.
    task automatic cycle_step(input bit wv, input int wd, input bit st, input bit rq,
                              input int ra, input bit cd, input bit ab);
        bit acc;
        bit rfire;
        bit rin;
        int exp_addr;
        @(negedge clk);
        wr_valid     = wv;
        wr_data      = DW'(wd);
        start        = st;
        rd_req       = rq;
        rd_addr      = AW'(ra);
        compute_done = cd;
        abort        = ab;
        #1;
        acc      = wv && (mode == M_LOAD);
        rfire    = rq && (mode == M_COMP);
        rin      = (ra < int'(NPIX));
        exp_addr = acc ? wcnt : ((rfire && rin) ? ra : last_addr);
        check_eq("wr_ready", int'(wr_ready), int'(mode == M_LOAD));
        check_eq("mem_we", int'(mem_we), int'(acc));
        check_eq("mem_addr", int'(mem_addr), exp_addr);
        if (acc) check_eq("mem_wdata", int'(mem_wdata), wd & 255);
        check_eq("img_ready", int'(img_ready), int'(mode == M_FULL));
        check_eq("busy", int'(busy), int'(mode == M_COMP));
        check_eq("rd_valid", int'(rd_valid), int'(pend_valid));
        if (pend_valid) check_eq("rd_data", int'(rd_data), pend_data);

        last_addr  = exp_addr;
        pend_valid = rfire;
        pend_data  = rin ? int'(img[ra]) : 0;
        if (acc) img[wcnt] = 8'(wd);
        if (ab) begin
            mode = M_LOAD;
            wcnt = 0;
        end else if (mode == M_LOAD) begin
            if (acc) begin
                if (wcnt == int'(NPIX) - 1) begin
                    wcnt = 0;
                    mode = M_FULL;
                end else begin
                    wcnt++;
                end
            end
        end else if (mode == M_FULL) begin
            if (st) mode = M_COMP;
        end else if (cd) begin
            mode = M_LOAD;
        end
    endtask

    task automatic idle_step();
        cycle_step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic read_step(input int ra);
        cycle_step(0, 0, 0, 1, ra, 0, 0);
    endtask

    // Stream n pixels; pattern data = index[7:0], otherwise random.
    task automatic load_pixels(input int n, input bit pattern, input bit start_first3_last);
        for (int i = 0; i < n; i++) begin
            cycle_step(1, pattern ? (i & 255) : int'($urandom_range(0, 255)),
                       start_first3_last && (i < 3 || i == n - 1), 0, 0, 0, 0);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ram[i] = '0;
            img[i] = '0;
        end
        reset        = 1'b1;
        wr_valid     = 1'b0;
        wr_data      = '0;
        start        = 1'b0;
        rd_req       = 1'b0;
        rd_addr      = '0;
        compute_done = 1'b0;
        abort        = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_rd_valid", int'(rd_valid), 0);
        check_eq("rst_rd_data", int'(rd_data), 0);
        check_eq("rst_img_ready", int'(img_ready), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_mem_addr", int'(mem_addr), 0);
        check_eq("rst_wr_ready", int'(wr_ready), 1);
        @(negedge clk);
        reset = 1'b0;

        // Start while idle in load, during load and on the final pixel: all ignored.
        cycle_step(0, 0, 1, 1, 3, 0, 0);
        load_pixels(int'(NPIX), 1, 1);
        idle_step();
        idle_step();
        check_eq("ram_783", int'(ram[783]), 8'h0F);

        // Claim the image and issue back-to-back reads at 0, 783, 784.
        cycle_step(0, 0, 1, 0, 0, 0, 0);
        read_step(0);
        read_step(783);
        read_step(784);
        idle_step();

        // Release together with a read at 5; next write must go to address 0.
        cycle_step(0, 0, 0, 1, 5, 1, 0);
        idle_step();
        cycle_step(1, 8'hA5, 0, 0, 0, 0, 0);

        // Abort mid-load with a write in the abort cycle, then a full new image.
        load_pixels(299, 0, 0);
        cycle_step(1, 8'h3C, 0, 0, 0, 0, 1);
        load_pixels(int'(NPIX) - 1, 0, 0);
        idle_step();
        load_pixels(1, 0, 0);
        cycle_step(0, 0, 1, 0, 0, 0, 0);
        read_step(0);
        read_step(299);
        read_step(300);
        read_step(1000);
        read_step(783);
        cycle_step(0, 0, 0, 1, 42, 0, 1);
        idle_step();

        // Random traffic.
        for (int c = 0; c < 4000; c++) begin
            cycle_step($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)),
                       $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1,
                       ($urandom_range(0, 3) == 0) ? int'($urandom_range(784, 1023))
                                                   : int'($urandom_range(0, 783)),
                       $urandom_range(0, 63) == 0, $urandom_range(0, 511) == 0);
        end

        // Asynchronous reset between edges in the middle of a compute.
        cycle_step(0, 0, 0, 0, 0, 0, 1);
        load_pixels(int'(NPIX), 0, 0);
        cycle_step(0, 0, 1, 0, 0, 0, 0);
        read_step(10);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_eq("arst_busy", int'(busy), 0);
        check_eq("arst_rd_valid", int'(rd_valid), 0);
        check_eq("arst_rd_data", int'(rd_data), 0);
        check_eq("arst_img_ready", int'(img_ready), 0);
        check_eq("arst_mem_addr", int'(mem_addr), 0);
        check_eq("arst_wr_ready", int'(wr_ready), 1);
        reset = 1'b0;
        model_reset();
        read_step(10);
        read_step(20);
        load_pixels(int'(NPIX), 0, 0);
        read_step(7);
        idle_step();
        cycle_step(0, 0, 1, 0, 0, 0, 0);
        read_step(7);
        read_step(500);
        idle_step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/img_mem_ctrl.md
IMG_MEM_CTRL -- requirements
Module: img_mem_ctrl

Interface
REQ-001 Parameters SHALL be: NPIX, 784, pixels per image (28x28); DW, 8, pixel width; AW, 10, address width.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 wr_valid  input  1  host offers a pixel.
REQ-005 wr_data  input  DW  host pixel value.
REQ-006 wr_ready  output  1  controller accepts the host pixel this cycle.
REQ-007 start  input  1  compute engine requests use of a complete image.
REQ-008 rd_req  input  1  compute engine read request.
REQ-009 rd_addr  input  AW  compute read address.
REQ-010 rd_valid  output  1  read data valid.
REQ-011 rd_data  output  DW  read data.
REQ-012 compute_done  input  1  compute engine releases the image.
REQ-013 abort  input  1  discard the current image and restart loading.
REQ-014 img_ready  output  1  complete image held, not yet claimed.
REQ-015 busy  output  1  compute owns memory.
REQ-016 mem_addr  output  AW  single-port RAM address.
REQ-017 mem_we  output  1  RAM write enable.
REQ-018 mem_wdata  output  DW  RAM write data.
REQ-019 mem_rdata  input  DW  RAM read data, valid one cycle after address.

Function
REQ-020 The FSM SHALL have states LOAD, FULL and COMPUTE.
REQ-021 wr_ready SHALL be 1 only in LOAD.
REQ-022 Write accept = wr_valid & wr_ready: mem_we=1, mem_addr=wr_cnt, mem_wdata=wr_data, combinationally in the same cycle.
REQ-023 wr_cnt (AW bits) SHALL increment on each accept and SHALL never exceed NPIX-1.
REQ-024 An accept at wr_cnt=NPIX-1 SHALL set wr_cnt to 0 and move LOAD->FULL; img_ready=1 from the next cycle.
REQ-025 In FULL, start=1 SHALL move to COMPUTE next cycle; img_ready=0 and busy=1 from the next cycle.
REQ-026 start outside FULL SHALL be ignored, including in the cycle the last pixel is accepted.
REQ-027 rd_req SHALL be serviced only in COMPUTE; it is ignored elsewhere and rd_valid stays 0.
REQ-028 In COMPUTE, rd_req with rd_addr<NPIX SHALL drive mem_addr=rd_addr with mem_we=0; rd_valid=1 and rd_data=mem_rdata one cycle later.
REQ-029 rd_req with rd_addr>=NPIX SHALL NOT address memory; rd_valid=1 and rd_data=0 one cycle later.
REQ-030 Back-to-back rd_req SHALL sustain one read per cycle.
REQ-031 compute_done in COMPUTE SHALL move to LOAD next cycle; a rd_req in the same cycle SHALL still be serviced.
REQ-032 abort SHALL force LOAD and wr_cnt=0 next cycle from any state, with priority over start and compute_done.
REQ-033 A write accepted in the abort cycle SHALL still reach memory but SHALL NOT advance wr_cnt.
REQ-034 Pending rd_valid SHALL still fire one cycle after an abort.
REQ-035 When idle, mem_we SHALL be 0 and mem_addr SHALL hold its last value.

Reset
REQ-036 Reset SHALL set state=LOAD, wr_cnt=0, rd_valid=0, rd_data=0, img_ready=0, busy=0 and mem_addr=0.
REQ-037 Reset mid-load or mid-compute SHALL discard all progress; RAM contents are not cleared.

Structure
REQ-038 A shared package SHALL hold the state enum (LOAD, FULL, COMPUTE) and constants NPIX_DEFAULT=784, PIX_W=8 and IMG_AW=10.
REQ-039 The pixel counter SHALL be one sub-module, img_pix_counter (clear, inc, count, last), instantiated once.

Verification
REQ-040 Stream 784 pixels (value = addr[7:0]) with wr_valid held high -> 784 consecutive mem_we pulses at addr 0..783, then img_ready=1, wr_ready=0.
REQ-041 Full image, start, reads at 0, 783, 784 back-to-back -> rd_valid on 3 consecutive cycles; data 0x00, 0x0F, 0x00; no mem access for 784.
REQ-042 start during load, and on the final-pixel cycle -> ignored; FSM stays LOAD then FULL; busy=0.
REQ-043 compute_done together with rd_req at 5 -> rd_valid with data 0x05 next cycle; state LOAD; wr_ready=1 with wr_cnt=0.
REQ-044 abort after 300 pixels, then 784 more -> image written at 0..783; img_ready only after the 784th new pixel.
REQ-045 Async reset pulse mid-compute between clock edges -> outputs at reset values immediately; rd_req ignored until start follows a new full load.
